// File: rtl/tod_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the time-of-day counter.
// Latency: n/a (package). Backpressure: n/a.
// 12-hour display conversion is only referenced when TOD_12H_MODE_EN is defined.
package tod_pkg;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        REJECT = 2'd3
    } tod_state_t;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } tod_time_t;

    // Both digits must be decimal before the numeric compare is meaningful.
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Returns {pm, hh12} for a valid 24-hour BCD value.
    function automatic logic [8:0] to_12h(input logic [7:0] hh24);
        logic [4:0] b;
        logic       pm;
        logic [7:0] h12;
        b  = 5'(hh24[7:4]) * 5'd10 + 5'(hh24[3:0]);
        pm = (b >= 5'd12);
        if (pm)
            b = b - 5'd12;
        if (b == 5'd0)
            b = 5'd12;
        h12 = (b >= 5'd10) ? {4'd1, 4'(b - 5'd10)} : {4'd0, b[3:0]};
        return {pm, h12};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX -> 00, with synchronous load and carry chain.
// Latency: value updates on the edge sampling inc/load; carry and value_nxt are combinational.
// Backpressure: none; load takes priority over inc and suppresses carry.
module bcd_mod_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] value,
    output logic [7:0] value_nxt,
    output logic       carry
);

    always_comb begin
        carry     = 1'b0;
        value_nxt = value;
        if (load) begin
            value_nxt = load_val;
        end else if (inc) begin
            if (value == MAX) begin
                value_nxt = 8'h00;
                carry     = 1'b1;
            end else if (value[3:0] == 4'd9) begin
                value_nxt = {value[7:4] + 4'd1, 4'd0};
            end else begin
                value_nxt = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= 8'h00;
        else
            value <= value_nxt;
    end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss clock driven by a 1 PPS tick, with range-checked set port and rollover strobes.
// Latency: 1 cycle from qualifying tick to time/strobes; set ack/err 3 cycles after acceptance.
// Backpressure: o_set_ready low for CHECK/COMMIT/REJECT; TOD_12H_MODE_EN adds 12-hour display + o_pm.
module time_of_day_counter #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_pulse,
    input  logic       i_set_valid,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic [7:0] i_set_ss,
    output logic       o_set_ready,
    output logic       o_set_ack,
    output logic       o_set_err,
`ifdef TOD_12H_MODE_EN
    output logic       o_pm,
`endif
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_min_tick,
    output logic       o_hour_tick,
    output logic       o_day_tick
);
    import tod_pkg::*;

    tod_state_t state, state_nxt;
    tod_time_t  cap;
    logic [7:0] prescale, prescale_nxt;
    logic       pending, pending_nxt;
    logic       pre_term, in_idle, commit, accept, sec_step, cap_ok;
    logic [7:0] ss_val, mm_val, hh_val;
    logic [7:0] ss_nxt, mm_nxt, hh_nxt;
    logic       ss_carry, mm_carry, hh_carry;

    assign in_idle  = (state == IDLE);
    assign commit   = (state == COMMIT);
    assign accept   = in_idle && i_set_valid && o_set_ready;
    assign pre_term = i_en && i_pulse && (prescale == 8'(TICKS_PER_SEC - 1));
    assign sec_step = in_idle && i_en && (pre_term || pending);
    assign cap_ok   = bcd_valid(cap.hh, HR_MAX) && bcd_valid(cap.mm, MIN_MAX)
                   && bcd_valid(cap.ss, SEC_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_set_valid && o_set_ready) state_nxt = CHECK;
            CHECK:   state_nxt = cap_ok ? COMMIT : REJECT;
            COMMIT:  state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A tick that lands while the set machine is busy is deferred to the
    // first IDLE cycle; if another tick qualifies in that cycle it re-arms.
    always_comb begin
        prescale_nxt = prescale;
        pending_nxt  = pending;
        if (commit)
            prescale_nxt = 8'h00;
        else if (i_en && i_pulse)
            prescale_nxt = pre_term ? 8'h00 : prescale + 8'h01;

        if (!in_idle) begin
            if (pre_term)
                pending_nxt = 1'b1;
        end else if (i_en) begin
            pending_nxt = pending && pre_term;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            prescale    <= 8'h00;
            pending     <= 1'b0;
            cap         <= '0;
            o_set_ready <= 1'b1;
            o_set_ack   <= 1'b0;
            o_set_err   <= 1'b0;
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
        end else begin
            state       <= state_nxt;
            prescale    <= prescale_nxt;
            pending     <= pending_nxt;
            if (accept)
                cap <= '{hh: i_set_hh, mm: i_set_mm, ss: i_set_ss};
            o_set_ready <= (state_nxt == IDLE);
            o_set_ack   <= commit;
            o_set_err   <= (state == REJECT);
            o_min_tick  <= ss_carry;
            o_hour_tick <= mm_carry;
            o_day_tick  <= hh_carry;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (commit),
        .load_val  (cap.ss),
        .inc       (sec_step),
        .value     (ss_val),
        .value_nxt (ss_nxt),
        .carry     (ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (commit),
        .load_val  (cap.mm),
        .inc       (ss_carry),
        .value     (mm_val),
        .value_nxt (mm_nxt),
        .carry     (mm_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (commit),
        .load_val  (cap.hh),
        .inc       (mm_carry),
        .value     (hh_val),
        .value_nxt (hh_nxt),
        .carry     (hh_carry)
    );

    assign o_mm = mm_val;
    assign o_ss = ss_val;

`ifdef TOD_12H_MODE_EN
    // Display register is fed from the counter's next value so it moves on the same edge.
    logic [7:0] hh_disp;
    logic       pm_disp;
    logic       unused_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hh_disp <= 8'h00;
            pm_disp <= 1'b0;
        end else begin
            {pm_disp, hh_disp} <= to_12h(hh_nxt);
        end
    end

    assign o_hh       = hh_disp;
    assign o_pm       = pm_disp;
    assign unused_nxt = ^{ss_nxt, mm_nxt, hh_val};
`else
    logic unused_nxt;

    assign o_hh       = hh_val;
    assign unused_nxt = ^{ss_nxt, mm_nxt, hh_nxt};
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed, table-driven bench for time_of_day_counter (TICKS_PER_SEC=1 and 4 instances).
// Hand-written sequences cover prescaling, enable gating, reset mid-commit and 12-hour display.
module tb_time_of_day_counter;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_pulse = 1'b0;
    logic       i_set_valid = 1'b0;
    logic [7:0] i_set_hh = 8'h00;
    logic [7:0] i_set_mm = 8'h00;
    logic [7:0] i_set_ss = 8'h00;

    logic       set_ready, set_ack, set_err, min_tick, hour_tick, day_tick;
    logic [7:0] hh, mm, ss;
    logic       set_ready_4, set_ack_4, set_err_4, min_tick_4, hour_tick_4, day_tick_4;
    logic [7:0] hh_4, mm_4, ss_4;
`ifdef TOD_12H_MODE_EN
    logic       pm, pm_4;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 i_clk = ~i_clk;

    time_of_day_counter #(.TICKS_PER_SEC(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_pulse(i_pulse),
        .i_set_valid(i_set_valid), .i_set_hh(i_set_hh), .i_set_mm(i_set_mm), .i_set_ss(i_set_ss),
        .o_set_ready(set_ready), .o_set_ack(set_ack), .o_set_err(set_err),
`ifdef TOD_12H_MODE_EN
        .o_pm(pm),
`endif
        .o_hh(hh), .o_mm(mm), .o_ss(ss),
        .o_min_tick(min_tick), .o_hour_tick(hour_tick), .o_day_tick(day_tick)
    );

    time_of_day_counter #(.TICKS_PER_SEC(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_pulse(i_pulse),
        .i_set_valid(i_set_valid), .i_set_hh(i_set_hh), .i_set_mm(i_set_mm), .i_set_ss(i_set_ss),
        .o_set_ready(set_ready_4), .o_set_ack(set_ack_4), .o_set_err(set_err_4),
`ifdef TOD_12H_MODE_EN
        .o_pm(pm_4),
`endif
        .o_hh(hh_4), .o_mm(mm_4), .o_ss(ss_4),
        .o_min_tick(min_tick_4), .o_hour_tick(hour_tick_4), .o_day_tick(day_tick_4)
    );

    typedef struct {
        logic       en, pulse, sv;
        logic [7:0] shh, smm, sss;
        logic [7:0] ehh, emm, ess;
        logic       eack, eerr, erdy, emin, ehour, eday;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Expected display form of a 24-hour BCD hour.
    function automatic logic [7:0] disp_hh(input logic [7:0] h);
`ifdef TOD_12H_MODE_EN
        int b, d;
        b = int'(h[7:4]) * 10 + int'(h[3:0]);
        d = b % 12;
        if (d == 0)
            d = 12;
        return bcd(d);
`else
        return h;
`endif
    endfunction

    function automatic vec_t mk(input logic en, input logic pulse, input logic sv,
                                input logic [7:0] shh, input logic [7:0] smm, input logic [7:0] sss,
                                input logic [7:0] ehh, input logic [7:0] emm, input logic [7:0] ess,
                                input logic eack, input logic eerr, input logic erdy,
                                input logic emin, input logic ehour, input logic eday);
        vec_t v;
        v.en = en; v.pulse = pulse; v.sv = sv;
        v.shh = shh; v.smm = smm; v.sss = sss;
        v.ehh = ehh; v.emm = emm; v.ess = ess;
        v.eack = eack; v.eerr = eerr; v.erdy = erdy;
        v.emin = emin; v.ehour = ehour; v.eday = eday;
        return v;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        i_set_valid = 1'b1; i_set_hh = h; i_set_mm = m; i_set_ss = s;
        step();
        i_set_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        // Columns: en pulse set_valid | set hh mm ss | exp hh mm ss | ack err ready | min hour day
        vt.push_back(mk(1,0,1, 8'h23,8'h59,8'h58, 8'h00,8'h01,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h01,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h23,8'h59,8'h58, 1,0,1, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h23,8'h59,8'h59, 0,0,1, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,1, 1,1,1));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h00,8'h60,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,1,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h00,8'h00,8'h1A, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,1,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h24,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,1,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h10,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h24,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,0,0, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,1,1, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h02, 0,0,1, 0,0,0));
        vt.push_back(mk(1,1,1, 8'h12,8'h34,8'h56, 8'h10,8'h00,8'h03, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h03, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h56, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h09,8'h59,8'h59, 8'h12,8'h34,8'h56, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h56, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h09,8'h59,8'h59, 1,0,1, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,1, 1,1,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h01,8'h02,8'h03, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h01,8'h02,8'h03, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h02,8'h04, 0,0,1, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h02,8'h04, 0,0,1, 0,0,0));
        vt.push_back(mk(0,1,0, 8'h00,8'h00,8'h00, 8'h01,8'h02,8'h04, 0,0,1, 0,0,0));
        vt.push_back(mk(0,1,1, 8'h05,8'h06,8'h07, 8'h01,8'h02,8'h04, 0,0,0, 0,0,0));
        vt.push_back(mk(0,1,0, 8'h00,8'h00,8'h00, 8'h01,8'h02,8'h04, 0,0,0, 0,0,0));
        vt.push_back(mk(0,1,0, 8'h00,8'h00,8'h00, 8'h05,8'h06,8'h07, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h05,8'h06,8'h07, 0,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h23,8'h59,8'h59, 8'h05,8'h06,8'h07, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h05,8'h06,8'h07, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h23,8'h59,8'h59, 1,0,1, 0,0,0));
        vt.push_back(mk(1,0,1, 8'h19,8'h59,8'h59, 8'h23,8'h59,8'h59, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h23,8'h59,8'h59, 0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 8'h19,8'h59,8'h59, 1,0,1, 0,0,0));
        vt.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 8'h20,8'h00,8'h00, 0,0,1, 1,1,0));

        // Reset state
        #12;
        chk("rst hh", hh, 8'h00);
        chk("rst mm", mm, 8'h00);
        chk("rst ss", ss, 8'h00);
        chk("rst ready", set_ready, 1'b1);
        chk("rst ack", set_ack, 1'b0);
        chk("rst err", set_err, 1'b0);
        chk("rst strobes", {min_tick, hour_tick, day_tick}, 3'b000);
        step();
        i_rst_n = 1'b1;
        step();

        // One minute of ticks at one advance per tick
        for (int i = 1; i <= 60; i++) begin
            i_en = 1'b1; i_pulse = 1'b1;
            step();
            chk($sformatf("min ss %0d", i), ss, bcd(i % 60));
            chk($sformatf("min tick %0d", i), min_tick, (i == 60));
            chk($sformatf("min hour %0d", i), hour_tick, 1'b0);
        end
        i_pulse = 1'b0;
        chk("min mm", mm, 8'h01);
        chk("min hh", hh, disp_hh(8'h00));

        for (int k = 0; k < vt.size(); k++) begin
            i_en = vt[k].en; i_pulse = vt[k].pulse; i_set_valid = vt[k].sv;
            i_set_hh = vt[k].shh; i_set_mm = vt[k].smm; i_set_ss = vt[k].sss;
            step();
            chk($sformatf("vec%0d hh", k), hh, disp_hh(vt[k].ehh));
            chk($sformatf("vec%0d mm", k), mm, vt[k].emm);
            chk($sformatf("vec%0d ss", k), ss, vt[k].ess);
            chk($sformatf("vec%0d ack", k), set_ack, vt[k].eack);
            chk($sformatf("vec%0d err", k), set_err, vt[k].eerr);
            chk($sformatf("vec%0d ready", k), set_ready, vt[k].erdy);
            chk($sformatf("vec%0d min", k), min_tick, vt[k].emin);
            chk($sformatf("vec%0d hour", k), hour_tick, vt[k].ehour);
            chk($sformatf("vec%0d day", k), day_tick, vt[k].eday);
        end
        i_pulse = 1'b0; i_set_valid = 1'b0; i_en = 1'b1;

        // Prescaler of 4 with a disabled window in the middle
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
        for (int p = 1; p <= 3; p++) begin
            i_pulse = 1'b1; step();
            i_pulse = 1'b0; step();
            chk($sformatf("pre4 ss en p%0d", p), ss_4, 8'h00);
        end
        i_en = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            i_pulse = 1'b1; step();
            chk($sformatf("pre4 ss dis p%0d", p), ss_4, 8'h00);
            chk($sformatf("pre4 strobe dis p%0d", p), min_tick_4, 1'b0);
            i_pulse = 1'b0; step();
        end
        i_en = 1'b1;
        i_pulse = 1'b1; step();
        chk("pre4 ss 4th", ss_4, 8'h01);
        i_pulse = 1'b0; step();
        for (int p = 1; p <= 4; p++) begin
            i_pulse = 1'b1; step();
            i_pulse = 1'b0;
            chk($sformatf("pre4 ss2 p%0d", p), ss_4, (p == 4) ? 8'h02 : 8'h01);
            step();
        end

        // Reset while the set machine is in COMMIT
        do_set(8'h22, 8'h22, 8'h22);
        chk("pre-rst hh", hh, disp_hh(8'h22));
        i_set_valid = 1'b1; i_set_hh = 8'h11; i_set_mm = 8'h11; i_set_ss = 8'h11;
        step();
        i_set_valid = 1'b0;
        step();
        i_rst_n = 1'b0;
        #1;
        chk("mid rst hh", hh, 8'h00);
        chk("mid rst mm", mm, 8'h00);
        chk("mid rst ss", ss, 8'h00);
        chk("mid rst ack", set_ack, 1'b0);
        chk("mid rst ready", set_ready, 1'b1);
        step();
        chk("mid rst ack2", set_ack, 1'b0);
        i_rst_n = 1'b1;
        step();
        chk("post rst ack", set_ack, 1'b0);
        chk("post rst ss", ss, 8'h00);
        chk("post rst hh", hh, disp_hh(8'h00));

`ifdef TOD_12H_MODE_EN
        do_set(8'h13, 8'h05, 8'h00);
        chk("12h hh 13", hh, 8'h01);
        chk("12h pm 13", pm, 1'b1);
        do_set(8'h00, 8'h00, 8'h00);
        chk("12h hh 00", hh, 8'h12);
        chk("12h pm 00", pm, 1'b0);
        do_set(8'h12, 8'h00, 8'h00);
        chk("12h hh 12", hh, 8'h12);
        chk("12h pm 12", pm, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Consumer end of the 1-pulse-per-second interface. Accepts the single-cycle `i_pulse` tick and maintains a BCD hours:minutes:seconds time of day for the seven-segment display path.
- Provides a valid/ready time-set port with range checking.
- Emits minute, hour and day rollover strobes for downstream alarm and date blocks.

Parameters:
- TICKS_PER_SEC, 1, number of `i_pulse` ticks per one-second advance (1..255); lets bench and simulation builds use faster tick sources.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_en  input  1  run enable; low freezes time (ticks ignored, prescaler held)
- i_pulse  input  1  tick, one cycle wide, from the pulse generator
- i_set_valid  input  1  time-set request
- i_set_hh  input  8  BCD hours to load (0x00..0x23)
- i_set_mm  input  8  BCD minutes to load (0x00..0x59)
- i_set_ss  input  8  BCD seconds to load (0x00..0x59)
- o_set_ready  output  1  set port can accept a request
- o_set_ack  output  1  one-cycle pulse: set committed
- o_set_err  output  1  one-cycle pulse: set rejected (out of range or non-BCD digit)
- o_hh  output  8  BCD hours
- o_mm  output  8  BCD minutes
- o_ss  output  8  BCD seconds
- o_min_tick  output  1  one-cycle pulse on ss 59->00
- o_hour_tick  output  1  one-cycle pulse on mm 59->00 with ss rollover
- o_day_tick  output  1  one-cycle pulse on 23:59:59->00:00:00

Behaviour:
- Reset values:
  - Time outputs: o_hh=o_mm=o_ss=0x00.
  - Strobes: o_set_ack=o_set_err=o_min_tick=o_hour_tick=o_day_tick=0.
  - o_set_ready=1, prescaler=0, FSM=IDLE, pending tick=0.
- All outputs are registered. A second advance appears on the edge that samples the qualifying `i_pulse` (1-cycle latency). Rollover strobes assert on that same edge.
- Prescaler:
  - Counts `i_pulse` while i_en=1.
  - On count==TICKS_PER_SEC-1 it advances time and clears.
  - With TICKS_PER_SEC=1, every tick advances.
- Advance arithmetic, per BCD digit with explicit carry:
  - ss units 9->0 carries to ss tens; ss tens 5->0 (at 59) carries to minutes.
  - mm follows the same rule as ss.
  - hh: units 9->0 carries to tens; 23->00 is a special case that raises o_day_tick.
- FSM states:
  - IDLE: o_set_ready=1. A tick advances time. On i_set_valid&&o_set_ready, capture i_set_* and go to CHECK.
  - CHECK (1 cycle): o_set_ready=0. Range- and digit-validate the captured value. Go to COMMIT if valid, REJECT if not.
  - COMMIT (1 cycle): load captured time, clear prescaler, pulse o_set_ack. Return to IDLE.
  - REJECT (1 cycle): keep current time, pulse o_set_err. Return to IDLE.
- Simultaneous events:
  - A tick in the same cycle a set is accepted is applied to the current time; the set then proceeds.
  - A qualifying tick during CHECK/COMMIT/REJECT sets a pending flag. The pending advance is applied in the first IDLE cycle, to the committed time or, if rejected, to the retained time. A second tick while pending is already set is dropped.
  - Pending flag and prescaler do not advance when i_en=0.
- i_en=0: time frozen, no strobes. The set port remains functional, and a set is honoured while disabled.
- Reset mid-operation: asynchronous return to reset values in any state. An in-flight set is discarded with no ack or error.
- Rollover strobes never assert on a set commit, even if the loaded value is 00:00:00.

Optional Feature:
- TOD_12H_MODE_EN defined:
  - Adds output o_pm (1 bit, reset 0).
  - o_hh presents the 12-hour form 0x01..0x12: 00->12 AM, 13..23 -> 01..11 PM.
  - The internal counter stays 24-hour. Set inputs remain 24-hour.
  - o_pm updates on the same edge as o_hh.
- Not defined: no o_pm port; o_hh is 24-hour BCD.

Decomposition:
- Shared package (`tod_pkg`):
  - BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23.
  - FSM state encoding: IDLE, CHECK, COMMIT, REJECT.
  - A BCD-validity function.
- Sub-module: `bcd_mod_counter`, a two-digit BCD counter with parameterised max, load, carry-in and carry-out. Instantiated three times (ss, mm, hh).

Test Plan:
- Reset, then 60 ticks with TICKS_PER_SEC=1 -> o_ss counts 0x00..0x59 then 0x00; o_mm=0x01; o_min_tick exactly once, on the 60th tick edge.
- Set 23:59:58 and expect ack, then 2 ticks -> 23:59:59 then 00:00:00; o_min_tick, o_hour_tick and o_day_tick all pulse on the same cycle.
- Set i_set_mm=0x60, then separately i_set_ss=0x1A -> o_set_err pulses each time, time unchanged, o_set_ready returns to 1 after 2 cycles.
- Tick arriving during CHECK of a valid set to 10:00:00 -> o_set_ack, then next cycle time=10:00:01; a tick during REJECT advances the old time by exactly 1 s.
- TICKS_PER_SEC=4, i_en toggled low for 3 ticks mid-sequence -> advance only after 4 ticks counted with i_en=1; no strobes while disabled.
- Assert i_rst_n low during COMMIT -> all outputs 0x00/0 immediately, no o_set_ack. With TOD_12H_MODE_EN: set 13:05:00 -> o_hh=0x01, o_pm=1; set 00:00:00 -> o_hh=0x12, o_pm=0.
